// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: header field widths,
// FSM state encoding and the header packing helper.
package router_pkg;

  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned LEN_W     = 6;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BUF_DEPTH = 64;

  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_e;

  function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: 64x8 register array with write/read pointers.
// Reading is combinational at the read pointer; rd_en advances it.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [LEN_W-1:0]  wr_ptr,
  output logic [LEN_W-1:0]  rd_ptr
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 6'd1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ptr  = wr_ptr_q;
  assign rd_ptr  = rd_ptr_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a whole payload, then sends header,
// payload and parity on the router bus, honouring busy backpressure.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned MIN_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic              corrupt_parity,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              packet_valid,
  output logic              tx_busy,
  output logic              done,
  output logic              err_req
);

  localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              corrupt_q, corrupt_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [3:0]        gap_q, gap_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              packet_valid_q, packet_valid_d;
  logic              pl_ready_q, pl_ready_d;
  logic              tx_busy_q, tx_busy_d;
  logic              done_q, done_d;
  logic              err_req_q, err_req_d;

  logic              buf_clear, buf_wr, buf_rd;
  logic [DATA_W-1:0] buf_rd_data;
  logic [LEN_W-1:0]  buf_wr_ptr, buf_rd_ptr;

  router_tx_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (buf_clear),
    .wr_en   (buf_wr),
    .wr_data (pl_data),
    .rd_en   (buf_rd),
    .rd_data (buf_rd_data),
    .wr_ptr  (buf_wr_ptr),
    .rd_ptr  (buf_rd_ptr)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    corrupt_d      = corrupt_q;
    parity_d       = parity_q;
    gap_d          = gap_q;
    data_out_d     = data_out_q;
    packet_valid_d = packet_valid_q;
    pl_ready_d     = pl_ready_q;
    done_d         = 1'b0;
    err_req_d      = 1'b0;
    buf_clear      = 1'b0;
    buf_wr         = 1'b0;
    buf_rd         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        data_out_d     = '0;
        packet_valid_d = 1'b0;
        pl_ready_d     = 1'b0;
        if (start) begin
          if (dest_addr == ILLEGAL_ADDR || payload_len == '0) begin
            err_req_d = 1'b1;
          end else begin
            addr_d     = dest_addr;
            len_d      = payload_len;
            corrupt_d  = corrupt_parity;
            parity_d   = '0;
            buf_clear  = 1'b1;
            pl_ready_d = 1'b1;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (pl_valid && pl_ready_q) begin
          buf_wr   = 1'b1;
          parity_d = parity_q ^ pl_data;
          if (buf_wr_ptr == len_q - 6'd1) begin
            pl_ready_d     = 1'b0;
            data_out_d     = make_header(len_q, addr_q);
            packet_valid_d = 1'b1;
            state_d        = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          parity_d   = parity_q ^ data_out_q;
          buf_rd     = 1'b1;
          data_out_d = buf_rd_data;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // rd_ptr already counts the byte currently on the bus.
        if (!busy) begin
          if (buf_rd_ptr == len_q) begin
            data_out_d     = corrupt_q ? ~parity_q : parity_q;
            packet_valid_d = 1'b0;
            state_d        = ST_PARITY;
          end else begin
            buf_rd     = 1'b1;
            data_out_d = buf_rd_data;
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          done_d     = 1'b1;
          data_out_d = '0;
          gap_d      = '0;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      corrupt_q      <= 1'b0;
      parity_q       <= '0;
      gap_q          <= '0;
      data_out_q     <= '0;
      packet_valid_q <= 1'b0;
      pl_ready_q     <= 1'b0;
      tx_busy_q      <= 1'b0;
      done_q         <= 1'b0;
      err_req_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      corrupt_q      <= corrupt_d;
      parity_q       <= parity_d;
      gap_q          <= gap_d;
      data_out_q     <= data_out_d;
      packet_valid_q <= packet_valid_d;
      pl_ready_q     <= pl_ready_d;
      tx_busy_q      <= tx_busy_d;
      done_q         <= done_d;
      err_req_q      <= err_req_d;
    end
  end

  assign data_out     = data_out_q;
  assign packet_valid = packet_valid_q;
  assign pl_ready     = pl_ready_q;
  assign tx_busy      = tx_busy_q;
  assign done         = done_q;
  assign err_req      = err_req_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx: normal packet, corrupted
// parity, backpressure, illegal requests, mid-packet reset, back-to-back.
module tb_router_pkt_tx;

  localparam int unsigned TB_GAP = 2;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       corrupt_parity;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       packet_valid;
  logic       tx_busy;
  logic       done;
  logic       err_req;

  int asserts = 0;
  int fails   = 0;
  logic [7:0] pay [64];

  router_pkt_tx #(.MIN_GAP(TB_GAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .dest_addr      (dest_addr),
    .payload_len    (payload_len),
    .corrupt_parity (corrupt_parity),
    .pl_data        (pl_data),
    .pl_valid       (pl_valid),
    .pl_ready       (pl_ready),
    .busy           (busy),
    .data_out       (data_out),
    .packet_valid   (packet_valid),
    .tx_busy        (tx_busy),
    .done           (done),
    .err_req        (err_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] a, input logic [5:0] l, input logic c, input bit hold);
    dest_addr      = a;
    payload_len    = l;
    corrupt_parity = c;
    start          = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  // Feeds pay[0..len-1] whenever pl_ready is high; optionally idles pl_valid every other cycle.
  task automatic load_payload(input int len, input bit toggle);
    int  idx;
    int  cyc;
    bit  xfer;
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 300) begin
      pl_valid = toggle ? ((cyc % 2) == 1) : 1'b1;
      pl_data  = pl_valid ? pay[idx] : ~pay[idx];
      xfer     = pl_valid && pl_ready;
      tick();
      if (xfer) idx++;
      cyc++;
    end
    pl_valid = 1'b0;
    pl_data  = 8'h00;
    asserts++;
    if (idx != len) begin
      fails++;
      $display("FAIL load_timeout: loaded %0d bytes, expected %0d", idx, len);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 50) begin
      tick();
      n++;
    end
    asserts++;
    if (tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout: tx_busy=%b expected 0", tx_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dest_addr = '0; payload_len = '0; corrupt_parity = 1'b0;
    pl_data = '0; pl_valid = 1'b0; busy = 1'b0;
    tick();
    tick();
    asserts++;
    if ({data_out, packet_valid, pl_ready, tx_busy, done, err_req} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: data=%h pv=%b rdy=%b txb=%b done=%b err=%b expected all 0",
               data_out, packet_valid, pl_ready, tx_busy, done, err_req);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic(input logic corrupt, input logic [7:0] exp_par);
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    request(2'd2, 6'd8, corrupt, 1'b0);
    asserts++;
    if ({tx_busy, pl_ready} !== 2'b11) begin
      fails++;
      $display("FAIL load_entry: txb=%b rdy=%b expected 1 1", tx_busy, pl_ready);
    end
    load_payload(8, 1'b0);
    asserts++;
    if ({packet_valid, data_out, pl_ready} !== {1'b1, 8'h22, 1'b0}) begin
      fails++;
      $display("FAIL header: pv=%b data=%h rdy=%b expected pv=1 data=22 rdy=0", packet_valid, data_out, pl_ready);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      asserts++;
      if ({packet_valid, data_out} !== {1'b1, pay[k]}) begin
        fails++;
        $display("FAIL payload[%0d]: pv=%b data=%h expected pv=1 data=%h", k, packet_valid, data_out, pay[k]);
      end
    end
    tick();
    asserts++;
    if ({packet_valid, data_out, done} !== {1'b0, exp_par, 1'b0}) begin
      fails++;
      $display("FAIL parity: pv=%b data=%h done=%b expected pv=0 data=%h done=0", packet_valid, data_out, done, exp_par);
    end
    tick();
    asserts++;
    if ({done, packet_valid, data_out, tx_busy} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL done_pulse: done=%b pv=%b data=%h txb=%b expected 1 0 00 1", done, packet_valid, data_out, tx_busy);
    end
    tick();
    asserts++;
    if ({done, tx_busy, packet_valid} !== 3'b010) begin
      fails++;
      $display("FAIL gap: done=%b txb=%b pv=%b expected 0 1 0", done, tx_busy, packet_valid);
    end
    tick();
    asserts++;
    if ({tx_busy, data_out} !== 9'h000) begin
      fails++;
      $display("FAIL gap_end: txb=%b data=%h expected 0 00", tx_busy, data_out);
    end
  endtask

  task automatic test_busy();
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    request(2'd2, 6'd8, 1'b0, 1'b0);
    load_payload(8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      asserts++;
      if ({packet_valid, data_out} !== {1'b1, pay[k]}) begin
        fails++;
        $display("FAIL busy_payload[%0d]: pv=%b data=%h expected pv=1 data=%h", k, packet_valid, data_out, pay[k]);
      end
      if (pay[k] == 8'h03) begin
        busy = 1'b1;
        for (int h = 0; h < 3; h++) begin
          tick();
          asserts++;
          if ({packet_valid, data_out} !== {1'b1, 8'h03}) begin
            fails++;
            $display("FAIL busy_hold[%0d]: pv=%b data=%h expected pv=1 data=03", h, packet_valid, data_out);
          end
        end
        busy = 1'b0;
      end
    end
    tick();
    asserts++;
    if ({packet_valid, data_out} !== {1'b0, 8'h2A}) begin
      fails++;
      $display("FAIL busy_parity: pv=%b data=%h expected pv=0 data=2a", packet_valid, data_out);
    end
    wait_idle();
  endtask

  task automatic test_illegal();
    request(2'd3, 6'd5, 1'b0, 1'b0);
    asserts++;
    if ({err_req, tx_busy, packet_valid, pl_ready} !== 4'b1000) begin
      fails++;
      $display("FAIL illegal_addr: err=%b txb=%b pv=%b rdy=%b expected 1 0 0 0", err_req, tx_busy, packet_valid, pl_ready);
    end
    tick();
    asserts++;
    if ({err_req, tx_busy} !== 2'b00) begin
      fails++;
      $display("FAIL illegal_addr_pulse: err=%b txb=%b expected 0 0", err_req, tx_busy);
    end
    request(2'd1, 6'd0, 1'b0, 1'b0);
    asserts++;
    if ({err_req, tx_busy, packet_valid} !== 3'b100) begin
      fails++;
      $display("FAIL illegal_len: err=%b txb=%b pv=%b expected 1 0 0", err_req, tx_busy, packet_valid);
    end
    tick();
    asserts++;
    if ({err_req, tx_busy, packet_valid} !== 3'b000) begin
      fails++;
      $display("FAIL illegal_len_pulse: err=%b txb=%b pv=%b expected 0 0 0", err_req, tx_busy, packet_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    request(2'd2, 6'd8, 1'b0, 1'b0);
    load_payload(8, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    asserts++;
    if (data_out !== 8'h05) begin
      fails++;
      $display("FAIL pre_reset_byte: data=%h expected 05", data_out);
    end
    reset = 1'b1;
    tick();
    asserts++;
    if ({data_out, packet_valid, pl_ready, tx_busy, done, err_req} !== 13'h0) begin
      fails++;
      $display("FAIL mid_reset: data=%h pv=%b rdy=%b txb=%b done=%b err=%b expected all 0",
               data_out, packet_valid, pl_ready, tx_busy, done, err_req);
    end
    reset = 1'b0;
    pay[0] = 8'hFF;
    request(2'd0, 6'd1, 1'b0, 1'b0);
    asserts++;
    if ({tx_busy, pl_ready} !== 2'b11) begin
      fails++;
      $display("FAIL post_reset_start: txb=%b rdy=%b expected 1 1", tx_busy, pl_ready);
    end
    load_payload(1, 1'b0);
    asserts++;
    if ({packet_valid, data_out} !== {1'b1, 8'h04}) begin
      fails++;
      $display("FAIL post_reset_header: pv=%b data=%h expected pv=1 data=04", packet_valid, data_out);
    end
    tick();
    asserts++;
    if ({packet_valid, data_out} !== {1'b1, 8'hFF}) begin
      fails++;
      $display("FAIL post_reset_payload: pv=%b data=%h expected pv=1 data=ff", packet_valid, data_out);
    end
    tick();
    asserts++;
    if ({packet_valid, data_out} !== {1'b0, 8'hFB}) begin
      fails++;
      $display("FAIL post_reset_parity: pv=%b data=%h expected pv=0 data=fb", packet_valid, data_out);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n;
    pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'h3C;
    request(2'd1, 6'd3, 1'b0, 1'b1);
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        tick();
        asserts++;
        if ({tx_busy, pl_ready} !== 2'b11) begin
          fails++;
          $display("FAIL b2b_restart: txb=%b rdy=%b expected 1 1", tx_busy, pl_ready);
        end
      end
      load_payload(3, 1'b1);
      asserts++;
      if ({packet_valid, data_out} !== {1'b1, 8'h0D}) begin
        fails++;
        $display("FAIL b2b_header[%0d]: pv=%b data=%h expected pv=1 data=0d", p, packet_valid, data_out);
      end
      for (int k = 0; k < 3; k++) begin
        tick();
        asserts++;
        if ({packet_valid, data_out} !== {1'b1, pay[k]}) begin
          fails++;
          $display("FAIL b2b_payload[%0d][%0d]: pv=%b data=%h expected pv=1 data=%h", p, k, packet_valid, data_out, pay[k]);
        end
      end
      tick();
      asserts++;
      if ({packet_valid, data_out} !== {1'b0, 8'hCE}) begin
        fails++;
        $display("FAIL b2b_parity[%0d]: pv=%b data=%h expected pv=0 data=ce", p, packet_valid, data_out);
      end
      if (p == 1) start = 1'b0;
      tick();
      n = 0;
      while (tx_busy && n < 20) begin
        if (packet_valid) n = 100;
        n++;
        tick();
      end
      asserts++;
      if (n != int'(TB_GAP)) begin
        fails++;
        $display("FAIL b2b_gap[%0d]: gap cycles %0d expected %0d", p, n, TB_GAP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0, 8'h2A);
    test_basic(1'b1, 8'hD5);
    test_busy();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter MIN_GAP, default 1, meaning idle cycles (1..15) with packet_valid=0 between a parity byte and the next header.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  packet request, sampled in IDLE only.
REQ-005 SHALL have port dest_addr  input  2  destination port 0..2; 3 is illegal.
REQ-006 SHALL have port payload_len  input  6  payload byte count 1..63; 0 is illegal.
REQ-007 SHALL have port corrupt_parity  input  1  when 1 at request, transmit the inverted parity byte.
REQ-008 SHALL have ports pl_data  input  8, pl_valid  input  1, pl_ready  output  1  payload byte stream; a byte moves on an edge with pl_valid=1 and pl_ready=1.
REQ-009 SHALL have port busy  input  1  router backpressure; 1 means the current byte is not taken.
REQ-010 SHALL have ports data_out  output  8 and packet_valid  output  1  router input bus.
REQ-011 SHALL have ports tx_busy  output  1 (not IDLE), done  output  1 (one-cycle pulse after parity accepted), err_req  output  1 (one-cycle pulse on illegal request).

Function
REQ-012 SHALL implement FSM IDLE -> LOAD -> HEADER -> PAYLOAD -> PARITY -> GAP -> IDLE; all outputs registered.
REQ-013 IDLE: start=1 with legal dest_addr and payload_len SHALL latch addr, len, corrupt_parity and enter LOAD next edge; start while not IDLE SHALL be ignored.
REQ-014 IDLE: start=1 with dest_addr=3 or payload_len=0 SHALL pulse err_req for one cycle and remain IDLE.
REQ-015 LOAD: pl_ready=1; each transferred byte SHALL be written to the payload buffer and XORed into the parity accumulator; after byte number len, enter HEADER (pl_ready=0 from that edge).
REQ-016 packet_valid SHALL never deassert between header and last payload byte (whole payload buffered before header).
REQ-017 HEADER: data_out={len[5:0],addr[1:0]}, packet_valid=1; header SHALL be XORed into parity.
REQ-018 A bus byte SHALL be accepted on an edge where busy=0; with busy=1 data_out and packet_valid SHALL hold unchanged.
REQ-019 PAYLOAD: buffer bytes in write order, packet_valid=1; after the len-th accepted byte, enter PARITY.
REQ-020 PARITY: data_out=parity (or ~parity if corrupt latched), packet_valid=0; held while busy=1; on acceptance pulse done and enter GAP.
REQ-021 GAP: data_out=0, packet_valid=0 for MIN_GAP cycles, then IDLE.
REQ-022 Latency: header SHALL be on the bus the cycle after the edge accepting the last payload byte into LOAD.
REQ-023 Parity SHALL equal XOR of header and all payload bytes, 8-bit, no carry.
REQ-024 pl_ready SHALL be 0 outside LOAD; data_out SHALL be 0 in IDLE.

Reset
REQ-025 reset=1 on a rising edge SHALL force IDLE, packet_valid=0, data_out=0, pl_ready=0, tx_busy=0, done=0, err_req=0, parity=0, buffer pointers 0, from any state including mid-packet.
REQ-026 After reset release the block SHALL accept start on the first following edge; a truncated packet SHALL NOT resume.

Structure
REQ-027 A shared package router_pkg SHALL hold the FSM state encoding, header field widths (ADDR_W=2, LEN_W=6), and ILLEGAL_ADDR=2'b11.
REQ-028 Payload storage SHALL be one sub-module router_tx_buf: 64x8 register array, write pointer/read pointer, synchronous clear.

Verification
REQ-029 addr=2, len=8, payload 0x01..0x08, busy=0 -> data_out 0x22, 0x01..0x08 with packet_valid=1, then 0x2A with packet_valid=0, done pulse, MIN_GAP idle cycles.
REQ-030 Same packet, corrupt_parity=1 -> parity byte 0xD5; header and payload unchanged.
REQ-031 busy=1 for 3 cycles while 0x03 on bus -> 0x03 held 3 extra cycles, packet_valid stays 1, no byte skipped or duplicated.
REQ-032 start with dest_addr=3, then payload_len=0 -> err_req pulse each, packet_valid never 1, tx_busy stays 0.
REQ-033 reset asserted during payload byte 5 -> next cycle all outputs 0; new request addr=0, len=1, byte 0xFF -> 0x04, 0xFF, 0xFB.
REQ-034 pl_valid toggling during LOAD and start held high throughout -> packet bytes correct, second packet header only after MIN_GAP.
